preamble_rep_inserter: RTL
==========================

// Module: preamble_rep_inserter
// PURPOSE
//  Transmit-side counterpart of the receive CFO corrector. Prepends a programmable training
//  period (NPER samples, repeated NITER times) ahead of every SC16 payload packet. The receiver
//  uses these repeats to estimate and remove CFO. Sits between axi_wrapper m_axis_data and
//  s_axis_data in an RFNoC CE, behind the noc_shell settings bus, all in ce_clk.
// PARAMETERS
//  SR_NPER      132  setting addr: period length, 8b
//  SR_NITER     133  setting addr: repetition count, 16b
//  SR_CTRL      134  setting addr: bit0 enable
//  SR_SEQ_ADDR  135  setting addr: sequence RAM write pointer, 8b
//  SR_SEQ_DATA  136  setting addr: 32b sample written at pointer, pointer auto-increments (wraps 255->0)
//  MAX_PER      256  sequence RAM depth (samples)
// PORTS
//  ce_clk       in   1   clock
//  ce_rst       in   1   synchronous active-high reset
//  clear        in   1   synchronous datapath clear (clear_tx_seqnum)
//  set_stb      in   1   settings strobe
//  set_addr     in   8   settings address
//  set_data     in   32  settings data
//  rb_addr      in   8   readback select
//  rb_data      out  64  readback: 1 NPER, 2 NITER, 3 CTRL, 4 {32'd0,pkt_cnt}, else 64'h0BADC0DE0BADC0DE
//  s_axis_tdata in   32  payload sample, SC16 {I,Q}
//  s_axis_tlast in   1   end of payload packet
//  s_axis_tvalid in  1
//  s_axis_tready out 1
//  m_axis_tdata out  32  preamble or payload sample
//  m_axis_tlast out  1   only on last payload sample
//  m_axis_tvalid out 1
//  m_axis_tready in  1
// BEHAVIOUR
//  Reset (ce_rst): FSM=IDLE, idx/iter=0, m_axis_tvalid=0, s_axis_tready=0, NPER/NITER/CTRL=0,
//   seq ptr=0, pkt_cnt=0. RAM contents not reset. clear: same except setting regs and RAM kept.
//  Settings: registers update the cycle after set_stb. Latched into shadows only in IDLE when a packet
//   starts; writes mid-packet take effect on the next packet. RAM writes are immediate.
//  FSM:
//   IDLE: s_axis_tready=0. On s_axis_tvalid: latch shadows; if en && NPER!=0 && NITER!=0 -> PRE,
//    else -> PAY.
//   PRE: s_axis_tready=0. Issue seq[idx]; on output acceptance idx++. When idx==NPER-1 then idx=0,
//    iter++. Last accepted sample (idx==NPER-1, iter==NITER-1) -> PAY. Preamble tlast=0 always.
//   PAY: pass s_axis to output, s_axis_tready = output stage ready. On accepted s_axis_tlast:
//    pkt_cnt++ (wraps 2^32-1 -> 0), -> IDLE.
//  Output: one registered stage (axi_fifo_flop-equivalent). Latency input->output 1 cycle; RAM is
//   sync-read, address prefetched so preamble runs 1 sample/cycle with no bubbles, including the
//   PRE->PAY boundary and back-to-back packets (at most 1 idle cycle in IDLE between packets).
//  Backpressure: m_axis_tready=0 holds idx/iter and output data stable; tvalid never drops
//   without handshake.
//  Total output per packet = NPER*NITER + payload length. NPER*NITER up to 255*65535 (no width
//   limit: counters are 8b and 16b).
//  NPER > MAX_PER impossible (8b). Payload of 1 sample (tvalid+tlast same beat) is legal.
//  Reset/clear mid-packet: output stage emptied same cycle, FSM->IDLE; remainder of the input
//   packet is then treated as a new packet (upstream clears too).
// STRUCTURE
//  Shared package: SR_* addresses, readback codes, FSM state enum {IDLE,PRE,PAY}.
//  Sub-module: preamble_seq_ram (256x32, 1 write port from settings, 1 sync read port).
//  Output register: existing axi_fifo_flop WIDTH=33.
// TESTING
//  1 Bypass: CTRL=0, 8-sample packet 0..7 -> same 8 samples, tlast on 7, latency 1.
//  2 NPER=4, NITER=3, RAM={A,B,C,D}, payload 5 samples -> ABCDABCDABCD + 5 payload samples;
//    tlast only on final; 17 beats in 17 cycles with tready=1.
//  3 Random m_axis_tready (50%) on case 2 -> identical sequence, no dropped/duplicated sample.
//  4 NITER written to 1 during PRE of packet 1 -> packet 1 keeps 3 repeats, packet 2 has 1;
//    readback 4 = 2.
//  5 SEQ_ADDR=255, two DATA writes -> samples land at 255 and 0; readback addr 9 = 0BADC0DE...
//  6 ce_rst asserted at iter=1 idx=2 -> next cycle m_axis_tvalid=0, rb NPER=0, FSM IDLE.

Source files
------------

// File: rtl/preamble_rep_inserter_pkg.sv
// Shared definitions for the preamble repetition inserter.
// Contents: settings-bus register addresses, readback select codes,
// the sequence RAM depth and the control FSM state type.
package preamble_rep_inserter_pkg;

  // Settings-bus register addresses
  localparam logic [7:0] SR_NPER     = 8'd132;  // period length (8b)
  localparam logic [7:0] SR_NITER    = 8'd133;  // repetition count (16b)
  localparam logic [7:0] SR_CTRL     = 8'd134;  // bit0: enable
  localparam logic [7:0] SR_SEQ_ADDR = 8'd135;  // sequence RAM write pointer
  localparam logic [7:0] SR_SEQ_DATA = 8'd136;  // sample at pointer, pointer++

  localparam int MAX_PER = 256;

  // Readback select codes
  localparam logic [7:0]  RB_NPER    = 8'd1;
  localparam logic [7:0]  RB_NITER   = 8'd2;
  localparam logic [7:0]  RB_CTRL    = 8'd3;
  localparam logic [7:0]  RB_PKT_CNT = 8'd4;
  localparam logic [63:0] RB_BAD     = 64'h0BADC0DE0BADC0DE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    PAY  = 2'd2
  } state_e;

endpackage

// File: rtl/preamble_rep_inserter_if.sv
// AXI-stream style sample bus used on both sides of the inserter.
// Ports: tdata (SC16 {I,Q}), tlast (end of packet), tvalid, tready.
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high. Once tvalid is raised the master holds tvalid, tdata and
// tlast unchanged until that transfer; tready may change freely.
interface preamble_rep_inserter_if;
  logic [31:0] tdata;
  logic        tlast;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/preamble_seq_ram.sv
// Training sequence storage: 256 x 32 samples.
// Ports: clk; we/waddr/wdata write port (from the settings bus);
// raddr/rdata synchronous read port (rdata valid the cycle after raddr).
// Contents are never reset.
module preamble_seq_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata
);

  logic [31:0] mem [0:255];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/preamble_rep_inserter.sv
// Prepends NITER repeats of an NPER-sample training sequence ahead of every
// SC16 payload packet, so the receiver can estimate and remove CFO.
// Ports:
//   ce_clk, ce_rst  clock, synchronous active-high reset
//   clear           synchronous datapath clear (settings and RAM kept)
//   set_stb/addr/data  settings bus write
//   rb_addr/rb_data    readback (1 NPER, 2 NITER, 3 CTRL, 4 pkt_cnt)
//   s_axis          payload input stream
//   m_axis          preamble + payload output stream (one register stage)
//   dbg_state       current control FSM state
module preamble_rep_inserter
  import preamble_rep_inserter_pkg::*;
(
  input  logic        ce_clk,
  input  logic        ce_rst,
  input  logic        clear,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic [7:0]  rb_addr,
  output logic [63:0] rb_data,
  preamble_rep_inserter_if.slave  s_axis,
  preamble_rep_inserter_if.master m_axis,
  output state_e      dbg_state
);

  // Settings registers
  logic [7:0]  nper;
  logic [15:0] niter;
  logic        en;
  logic [7:0]  seq_ptr;
  logic        ram_we;

  assign ram_we = set_stb && (set_addr == SR_SEQ_DATA);

  always_ff @(posedge ce_clk) begin
    if (ce_rst) begin
      nper    <= '0;
      niter   <= '0;
      en      <= 1'b0;
      seq_ptr <= '0;
    end else if (set_stb) begin
      case (set_addr)
        SR_NPER:     nper    <= set_data[7:0];
        SR_NITER:    niter   <= set_data[15:0];
        SR_CTRL:     en      <= set_data[0];
        SR_SEQ_ADDR: seq_ptr <= set_data[7:0];
        SR_SEQ_DATA: seq_ptr <= seq_ptr + 8'd1;
        default: ;
      endcase
    end
  end

  // Datapath state
  state_e      state_q, state_d;
  logic [7:0]  sh_nper, idx_q, idx_d;
  logic [15:0] sh_niter, iter_q, iter_d;
  logic [31:0] pkt_cnt;
  logic [31:0] rd_data;
  logic        idx_wrap, iter_wrap, pre_last;

  // Output register stage
  logic        out_valid, out_last, out_ready;
  logic [31:0] out_data;
  logic        push, push_last, s_ready;
  logic [31:0] push_data;

  assign out_ready = !out_valid || m_axis.tready;
  assign idx_wrap  = (idx_q == sh_nper - 8'd1);
  assign iter_wrap = (iter_q == sh_niter - 16'd1);
  assign pre_last  = idx_wrap && iter_wrap;

  // The RAM is addressed with the index the next cycle will use, so rd_data
  // always holds seq[idx_q] and the preamble streams without bubbles.
  preamble_seq_ram u_seq_ram (
    .clk   (ce_clk),
    .we    (ram_we),
    .waddr (seq_ptr),
    .wdata (set_data),
    .raddr (idx_d),
    .rdata (rd_data)
  );

  // FSM: state register
  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) state_q <= IDLE;
    else                 state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (s_axis.tvalid)
              state_d = (en && nper != 8'd0 && niter != 16'd0) ? PRE : PAY;
      PRE:  if (out_ready && pre_last) state_d = PAY;
      PAY:  if (s_axis.tvalid && out_ready && s_axis.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    s_ready   = 1'b0;
    push      = 1'b0;
    push_data = rd_data;
    push_last = 1'b0;
    case (state_q)
      PRE: push = out_ready;
      PAY: begin
        s_ready   = out_ready;
        push      = s_axis.tvalid && out_ready;
        push_data = s_axis.tdata;
        push_last = s_axis.tlast;
      end
      default: ;
    endcase
  end

  assign s_axis.tready = s_ready;
  assign dbg_state     = state_q;

  // Preamble position advance
  always_comb begin
    idx_d  = idx_q;
    iter_d = iter_q;
    if (state_q == PRE && push) begin
      if (idx_wrap) begin
        idx_d  = '0;
        iter_d = iter_wrap ? 16'd0 : iter_q + 16'd1;
      end else begin
        idx_d = idx_q + 8'd1;
      end
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      idx_q    <= '0;
      iter_q   <= '0;
      sh_nper  <= '0;
      sh_niter <= '0;
      pkt_cnt  <= '0;
    end else begin
      idx_q  <= idx_d;
      iter_q <= iter_d;
      // Shadows freeze the period geometry for the whole packet
      if (state_q == IDLE && s_axis.tvalid) begin
        sh_nper  <= nper;
        sh_niter <= niter;
      end
      if (state_q == PAY && push && s_axis.tlast) pkt_cnt <= pkt_cnt + 32'd1;
    end
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      out_valid <= 1'b0;
    end else if (push) begin
      out_valid <= 1'b1;
    end else if (m_axis.tready) begin
      out_valid <= 1'b0;
    end
    if (push) begin
      out_data <= push_data;
      out_last <= push_last;
    end
  end

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;

  // Readback
  always_comb begin
    rb_data = RB_BAD;
    case (rb_addr)
      RB_NPER:    rb_data = {56'd0, nper};
      RB_NITER:   rb_data = {48'd0, niter};
      RB_CTRL:    rb_data = {63'd0, en};
      RB_PKT_CNT: rb_data = {32'd0, pkt_cnt};
      default: ;
    endcase
  end

endmodule
